// File: rtl/rf_ex_hazard_ctrl_if.sv
// rtl/rf_ex_hazard_ctrl_if.sv - RF/EX hazard control bundle: pipeline observations in, stall/flush controls out
//   master : pipeline side, drives the RF/EX and ID/RF observations and redirect_ex, receives the controls
//   slave  : hazard controller, receives the observations, drives en_*, flush_*, multi_* and stall_count
interface rf_ex_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             Valid_rf_ex;
    logic [3:0]       opcode_rf_ex;
    logic [1:0]       Memory_rf_ex;
    logic [2:0]       Dest_rf_ex;
    logic [7:0]       reg_list_rf_ex;
    logic             Valid_id_rf;
    logic [3:0]       src1_id_rf;
    logic [3:0]       src2_id_rf;
    logic             redirect_ex;
    logic             en_pc;
    logic             en_if_id;
    logic             en_id_rf;
    logic             en_rf_ex;
    logic             flush_if_id;
    logic             flush_id_rf;
    logic             flush_rf_ex;
    logic             multi_active;
    logic [2:0]       multi_idx;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output Valid_rf_ex, opcode_rf_ex, Memory_rf_ex, Dest_rf_ex, reg_list_rf_ex,
               Valid_id_rf, src1_id_rf, src2_id_rf, redirect_ex,
        input  en_pc, en_if_id, en_id_rf, en_rf_ex, flush_if_id, flush_id_rf, flush_rf_ex,
               multi_active, multi_idx, stall_count
    );

    modport slave (
        input  Valid_rf_ex, opcode_rf_ex, Memory_rf_ex, Dest_rf_ex, reg_list_rf_ex,
               Valid_id_rf, src1_id_rf, src2_id_rf, redirect_ex,
        output en_pc, en_if_id, en_id_rf, en_rf_ex, flush_if_id, flush_id_rf, flush_rf_ex,
               multi_active, multi_idx, stall_count
    );
endinterface

// File: rtl/rf_ex_hazard_ctrl.sv
// rtl/rf_ex_hazard_ctrl.sv - stall/flush control for PC, IF/ID, ID/RF, RF/EX: load-use, LM/SM sequencing, redirects
//   clock, reset : single clock, synchronous active-low reset
//   hz (slave)   : RF/EX and ID/RF observations plus redirect_ex in; register enables, flushes,
//                  LM/SM progress (multi_active, multi_idx) and saturating stall_count out
module rf_ex_hazard_ctrl #(
    parameter logic [3:0] LW_OP = 4'b0100,
    parameter logic [3:0] LM_OP = 4'b0110,
    parameter logic [3:0] SM_OP = 4'b0111,
    parameter int         CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    rf_ex_hazard_ctrl_if.slave hz
);
    typedef enum logic {
        RUN   = 1'b0,
        MULTI = 1'b1
    } state_e;

    state_e           st_q, st_d;
    logic [7:0]       mask_q, mask_d;
    logic [7:0]       list_q, list_d;
    logic             lm_q, lm_d;
    logic [CNT_W-1:0] stall_q;

    // en_c = {pc, if_id, id_rf, rf_ex}, fl_c = {if_id, id_rf, rf_ex}
    logic [3:0] en_c;
    logic [2:0] fl_c;
    logic       ma_c;
    logic [2:0] idx_c;
    logic       final_c;
    logic       final_lm;
    logic [7:0] final_list;
    logic [7:0] dep_vec;
    logic       lm_ex;
    logic       load_use;

    function automatic logic [2:0] lowest(input logic [7:0] x);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (x[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Two or more bits set: clearing the lowest set bit leaves something behind.
    function automatic logic two_plus(input logic [7:0] x);
        return (x & (x - 8'd1)) != 8'd0;
    endfunction

    // dep_vec[r] = the ID/RF instruction reads register r
    always_comb begin
        dep_vec = 8'd0;
        for (int r = 0; r < 8; r++) begin
            dep_vec[r] = hz.Valid_id_rf &
                         ((hz.src1_id_rf[3] && (hz.src1_id_rf[2:0] == 3'(r))) ||
                          (hz.src2_id_rf[3] && (hz.src2_id_rf[2:0] == 3'(r))));
        end
    end

    assign lm_ex    = hz.Valid_rf_ex && ((hz.opcode_rf_ex == LM_OP) || (hz.opcode_rf_ex == SM_OP));
    assign load_use = hz.Valid_rf_ex && (hz.opcode_rf_ex == LW_OP) && hz.Memory_rf_ex[1] &&
                      dep_vec[hz.Dest_rf_ex];

    always_comb begin
        st_d       = st_q;
        mask_d     = mask_q;
        list_d     = list_q;
        lm_d       = lm_q;
        en_c       = 4'b1111;
        fl_c       = 3'b000;
        ma_c       = 1'b0;
        idx_c      = 3'd0;
        final_c    = 1'b0;
        final_lm   = 1'b0;
        final_list = 8'd0;

        if (!reset) begin
            fl_c   = 3'b111;
            st_d   = RUN;
            mask_d = 8'd0;
            list_d = 8'd0;
            lm_d   = 1'b0;
        end else if (hz.redirect_ex) begin
            fl_c   = 3'b111;
            st_d   = RUN;
            mask_d = 8'd0;
        end else if (st_q == MULTI) begin
            ma_c   = 1'b1;
            idx_c  = lowest(mask_q);
            mask_d = mask_q & (mask_q - 8'd1);
            if (two_plus(mask_q)) begin
                en_c = 4'b0000;
            end else begin
                st_d       = RUN;
                final_c    = 1'b1;
                final_lm   = lm_q;
                final_list = list_q;
            end
        end else if (lm_ex) begin
            idx_c = lowest(hz.reg_list_rf_ex);
            if (two_plus(hz.reg_list_rf_ex)) begin
                en_c   = 4'b0000;
                ma_c   = 1'b1;
                st_d   = MULTI;
                mask_d = hz.reg_list_rf_ex & (hz.reg_list_rf_ex - 8'd1);
                list_d = hz.reg_list_rf_ex;
                lm_d   = (hz.opcode_rf_ex == LM_OP);
            end else begin
                // zero or one register: the entry cycle is also the last transfer
                final_c    = 1'b1;
                final_lm   = (hz.opcode_rf_ex == LM_OP);
                final_list = hz.reg_list_rf_ex;
            end
        end else if (load_use) begin
            en_c = 4'b0001;
            fl_c = 3'b001;
        end

        // Last LM transfer feeding a waiting consumer: one bubble into RF/EX,
        // front end held so the consumer re-reads the freshly loaded value.
        if (final_c && final_lm && ((final_list & dep_vec) != 8'd0)) begin
            en_c = 4'b0001;
            fl_c = 3'b001;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            st_q    <= RUN;
            mask_q  <= 8'd0;
            list_q  <= 8'd0;
            lm_q    <= 1'b0;
            stall_q <= '0;
        end else begin
            st_q   <= st_d;
            mask_q <= mask_d;
            list_q <= list_d;
            lm_q   <= lm_d;
            if (!en_c[3] && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign hz.en_pc        = en_c[3];
    assign hz.en_if_id     = en_c[2];
    assign hz.en_id_rf     = en_c[1];
    assign hz.en_rf_ex     = en_c[0];
    assign hz.flush_if_id  = fl_c[2];
    assign hz.flush_id_rf  = fl_c[1];
    assign hz.flush_rf_ex  = fl_c[0];
    assign hz.multi_active = ma_c;
    assign hz.multi_idx    = idx_c;
    assign hz.stall_count  = stall_q;
endmodule

// File: tb/tb_rf_ex_hazard_ctrl.sv
// tb/tb_rf_ex_hazard_ctrl.sv - self-checking bench for rf_ex_hazard_ctrl against a queue-based reference model
module tb_rf_ex_hazard_ctrl;
    localparam int         CNT_W = 5;
    localparam logic [3:0] LW    = 4'b0100;
    localparam logic [3:0] LM    = 4'b0110;
    localparam logic [3:0] SM    = 4'b0111;
    localparam int         CMAX  = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    rf_ex_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    rf_ex_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    // reference model state: remaining transfers and the list latched at entry
    bit m_multi = 1'b0;
    bit m_lm    = 1'b0;
    int rem[$];
    int orig[$];
    int m_cnt   = 0;
    bit cnt_known = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit dep_m(int r);
        return hz.Valid_id_rf &&
               ((hz.src1_id_rf[3] && int'(hz.src1_id_rf[2:0]) == r) ||
                (hz.src2_id_rf[3] && int'(hz.src2_id_rf[2:0]) == r));
    endfunction

    function automatic bit any_dep(int q[$]);
        foreach (q[i]) if (dep_m(q[i])) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_cycle(input bit rst, input bit vrx, input logic [3:0] op, input logic [1:0] mem,
                            input logic [2:0] dest, input logic [7:0] lst, input bit vid,
                            input logic [3:0] s1, input logic [3:0] s2, input bit redir);
        logic [3:0] e_en;
        logic [2:0] e_fl;
        bit         e_ma, ma_care;
        int         e_idx;
        int         q[$];
        bit         is_lm;
        @(negedge clock);
        reset             = rst;
        hz.Valid_rf_ex    = vrx;
        hz.opcode_rf_ex   = op;
        hz.Memory_rf_ex   = mem;
        hz.Dest_rf_ex     = dest;
        hz.reg_list_rf_ex = lst;
        hz.Valid_id_rf    = vid;
        hz.src1_id_rf     = s1;
        hz.src2_id_rf     = s2;
        hz.redirect_ex    = redir;
        #1;
        e_en = 4'b1111; e_fl = 3'b000; e_ma = 1'b0; ma_care = 1'b1; e_idx = 0;
        if (!rst || redir) begin
            e_fl = 3'b111;
            m_multi = 1'b0;
            rem.delete();
        end else if (m_multi) begin
            e_ma  = 1'b1;
            e_idx = rem[0];
            rem.delete(0);
            if (rem.size() > 0) begin
                e_en = 4'b0000;
            end else begin
                m_multi = 1'b0;
                if (m_lm && any_dep(orig)) begin e_en = 4'b0001; e_fl = 3'b001; end
            end
        end else if (vrx && (op == LM || op == SM)) begin
            for (int i = 0; i < 8; i++) if (lst[i]) q.push_back(i);
            is_lm = (op == LM);
            e_idx = (q.size() > 0) ? q[0] : 0;
            if (q.size() >= 2) begin
                e_en = 4'b0000;
                e_ma = 1'b1;
                m_multi = 1'b1;
                m_lm = is_lm;
                orig = q;
                rem = q;
                rem.delete(0);
            end else begin
                ma_care = 1'b0;
                if (is_lm && any_dep(q)) begin e_en = 4'b0001; e_fl = 3'b001; end
            end
        end else if (vrx && op == LW && mem[1] && dep_m(int'(dest))) begin
            e_en = 4'b0001;
            e_fl = 3'b001;
        end

        chk("en", {28'd0, hz.en_pc, hz.en_if_id, hz.en_id_rf, hz.en_rf_ex}, {28'd0, e_en});
        chk("flush", {29'd0, hz.flush_if_id, hz.flush_id_rf, hz.flush_rf_ex}, {29'd0, e_fl});
        if (ma_care) chk("multi_active", {31'd0, hz.multi_active}, {31'd0, e_ma});
        chk("multi_idx", {29'd0, hz.multi_idx}, e_idx);
        if (cnt_known) chk("stall_count", {27'd0, hz.stall_count}, m_cnt);

        if (!rst) begin
            m_cnt = 0;
            cnt_known = 1'b1;
        end else if (!e_en[3] && m_cnt < CMAX) begin
            m_cnt++;
        end
    endtask

    task automatic idle(input bit rst);
        do_cycle(rst, 1'b0, 4'h0, 2'b00, 3'd0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    initial begin
        logic [3:0] ops [4];
        logic [3:0] rop;
        bit         rvrx;
        logic [1:0] rmem;
        logic [2:0] rdest;
        logic [7:0] rlst;
        ops[0] = LW; ops[1] = LM; ops[2] = SM; ops[3] = 4'b0000;

        // reset, then idle
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // load-use on R3, then the bubble (invalid) reaches RF/EX
        do_cycle(1'b1, 1'b1, LW, 2'b10, 3'd3, 8'h00, 1'b1, 4'b1011, 4'b0000, 1'b0);
        do_cycle(1'b1, 1'b0, LW, 2'b10, 3'd3, 8'h00, 1'b1, 4'b1011, 4'b0000, 1'b0);
        chk("lu_stall_count", {27'd0, hz.stall_count}, 32'd1);

        // LM R2,R5,R7, no consumer
        repeat (3) do_cycle(1'b1, 1'b1, LM, 2'b10, 3'd0, 8'b1010_0100, 1'b0, 4'h0, 4'h0, 1'b0);
        idle(1'b1);
        chk("lm3_stall_count", {27'd0, hz.stall_count}, 32'd3);

        // single-register LM R3 with a consumer on src2
        do_cycle(1'b1, 1'b1, LM, 2'b10, 3'd0, 8'b0000_1000, 1'b1, 4'b0000, 4'b1011, 1'b0);
        idle(1'b1);

        // redirect overrides a load-use
        do_cycle(1'b1, 1'b1, LW, 2'b10, 3'd3, 8'h00, 1'b1, 4'b1011, 4'b0000, 1'b1);
        idle(1'b1);

        // SM with a full list, then the last LM transfer of a multi list with a consumer
        repeat (8) do_cycle(1'b1, 1'b1, SM, 2'b00, 3'd0, 8'hFF, 1'b1, 4'b1000, 4'b1001, 1'b0);
        repeat (2) do_cycle(1'b1, 1'b1, LM, 2'b10, 3'd0, 8'h81, 1'b1, 4'b1111, 4'b0000, 1'b0);
        idle(1'b1);

        // reset on the 3rd cycle of LM 8'hFF
        repeat (2) do_cycle(1'b1, 1'b1, LM, 2'b10, 3'd0, 8'hFF, 1'b0, 4'h0, 4'h0, 1'b0);
        do_cycle(1'b0, 1'b1, LM, 2'b10, 3'd0, 8'hFF, 1'b0, 4'h0, 4'h0, 1'b0);
        do_cycle(1'b1, 1'b0, LM, 2'b10, 3'd0, 8'hFF, 1'b0, 4'h0, 4'h0, 1'b0);

        // long stall run to reach counter saturation
        repeat (CMAX + 4) do_cycle(1'b1, 1'b1, LW, 2'b10, 3'd6, 8'h00, 1'b1, 4'b1110, 4'b0000, 1'b0);
        chk("sat_stall_count", {27'd0, hz.stall_count}, CMAX);
        idle(1'b1);

        // randomized traffic; RF/EX held steady while an LM/SM sequence is in progress
        for (int n = 0; n < 4000; n++) begin
            if (m_multi) begin
                rvrx = hz.Valid_rf_ex; rop = hz.opcode_rf_ex; rmem = hz.Memory_rf_ex;
                rdest = hz.Dest_rf_ex; rlst = hz.reg_list_rf_ex;
            end else begin
                rvrx  = ($urandom_range(0, 4) != 0);
                rop   = ops[$urandom_range(0, 3)];
                rmem  = 2'($urandom_range(0, 3));
                rdest = 3'($urandom_range(0, 7));
                rlst  = 8'($urandom_range(0, 255));
            end
            do_cycle(($urandom_range(0, 63) != 0), rvrx, rop, rmem, rdest, rlst,
                     ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 11) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
